// File: rtl/prog_sequencer.sv
// Fetch/execute sequencer for the accumulator processor: owns the PC, sequences
// FETCH -> EXEC -> (MEM) and produces commit, memory timing and Done.
module prog_sequencer #(
    parameter int PC_W    = 10,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             halt,
    input  logic             branch,
    input  logic             Lookup,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             taken,
    input  logic [3:0]       operand,
    input  logic [PC_W-1:0]  lut_target,
    output logic [PC_W-1:0]  PC,
    output logic             ir_load,
    output logic             commit,
    output logic             mem_req,
    output logic             mem_we,
    output logic             Done,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALT
    } state_t;

    state_t           state, state_n;
    logic [PC_W-1:0]  pc_q, pc_n;
    logic [3:0]       mem_cnt, mem_cnt_n;
    logic             we_q, we_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] count_inc;
    logic [PC_W-1:0]  pc_plus1;
    logic [PC_W-1:0]  rel_target;

    assign count_inc  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    assign pc_plus1   = pc_q + PC_W'(1);
    assign rel_target = pc_q + {{(PC_W-4){operand[3]}}, operand};

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        mem_cnt_n = mem_cnt;
        we_n      = we_q;
        count_n   = count_q;
        commit    = 1'b0;
        unique case (state)
            IDLE, HALT: begin
                if (Start) begin
                    state_n = FETCH;
                    pc_n    = '0;
                    count_n = '0;
                end
            end
            FETCH: state_n = EXEC;
            EXEC: begin
                // halt outranks memory ops, which outrank ALU/branch retirement
                if (halt) begin
                    state_n = HALT;
                end else if (MemRead || MemWrite) begin
                    state_n   = MEM;
                    mem_cnt_n = 4'(MEM_LAT - 1);
                    we_n      = MemWrite;
                end else begin
                    commit  = 1'b1;
                    count_n = count_inc;
                    state_n = FETCH;
                    if (branch && taken)
                        pc_n = Lookup ? lut_target : rel_target;
                    else
                        pc_n = pc_plus1;
                end
            end
            MEM: begin
                if (mem_cnt == 4'd0) begin
                    commit  = ~we_q;
                    count_n = count_inc;
                    pc_n    = pc_plus1;
                    state_n = FETCH;
                end else begin
                    mem_cnt_n = mem_cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            mem_cnt <= '0;
            we_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            mem_cnt <= mem_cnt_n;
            we_q    <= we_n;
            count_q <= count_n;
        end
    end

    assign PC          = pc_q;
    assign ir_load     = (state == FETCH);
    assign mem_req     = (state == MEM);
    assign mem_we      = (state == MEM) && we_q;
    assign Done        = (state == HALT);
    assign busy        = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign instr_count = count_q;

endmodule
